// File: rtl/k_and_s_control_unit.sv
// rtl/k_and_s_control_unit.sv - K&S processor multi-cycle control unit (fetch/decode/execute/writeback/branch/halt)
//
// k_and_s_pkg : decoded_instruction_type shared with the datapath decoder.
//
// k_and_s_control_unit ports:
//   clk, rst_n            - rising-edge clock, asynchronous active-low reset
//   decoded_instruction   - opcode from the datapath decoder, sampled only in DECODE
//   zero_op, neg_op,
//   unsigned_overflow,
//   signed_overflow       - registered ALU flags from the datapath
//   branch, pc_enable     - PC load select / PC update strobe
//   ir_enable             - instruction register load strobe
//   addr_sel              - RAM address select (0 = PC, 1 = mem_addr)
//   c_sel                 - register write source (0 = ALU, 1 = RAM data)
//   operation             - ALU op: 00 OR, 01 ADD, 10 SUB, 11 AND
//   write_reg_enable      - register file write strobe
//   flags_reg_enable      - flags register update strobe
//   ram_write_enable      - RAM write strobe
//   halt                  - sticky halted indication
//   retired_count         - retired instruction counter, wraps

package k_and_s_pkg;
    typedef enum logic [3:0] {
        I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR,
        I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV, I_HALT
    } decoded_instruction_type;
endpackage

module k_and_s_control_unit
    import k_and_s_pkg::*;
#(
    parameter int MEM_WAIT_CYCLES = 1,
    parameter int COUNT_W         = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic [1:0]              operation,
    output logic                    write_reg_enable,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
    output logic                    halt,
    output logic [COUNT_W-1:0]      retired_count
);

    typedef enum logic [3:0] {
        ST_RESET,
        ST_FETCH_ADDR,
        ST_FETCH_WAIT,
        ST_FETCH_LATCH,
        ST_DECODE,
        ST_EXEC_ALU,
        ST_LOAD_ADDR,
        ST_LOAD_WAIT,
        ST_LOAD_WB,
        ST_STORE_ADDR,
        ST_STORE_WR,
        ST_BRANCH,
        ST_HALT
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT_CYCLES - 1);

    state_t                  state;
    state_t                  next_state;
    logic [3:0]              wait_cnt;
    logic                    wait_done;
    logic                    in_wait;
    decoded_instruction_type instr_q;
    logic                    taken;
    logic                    retire;

    assign in_wait   = (state == ST_FETCH_WAIT) || (state == ST_LOAD_WAIT);
    assign wait_done = (wait_cnt == WAIT_LAST);
    // Every completed instruction re-enters FETCH_ADDR; only the exit from RESET is not a retirement.
    assign retire    = (next_state == ST_FETCH_ADDR) && (state != ST_RESET);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_RESET;
            wait_cnt      <= 4'd0;
            instr_q       <= I_NOP;
            retired_count <= '0;
        end else begin
            state <= next_state;
            if (in_wait && !wait_done) begin
                wait_cnt <= wait_cnt + 4'd1;
            end else begin
                wait_cnt <= 4'd0;
            end
            // Latching the opcode in DECODE makes later changes on the input harmless.
            if (state == ST_DECODE) begin
                instr_q <= decoded_instruction;
            end
            if (retire) begin
                retired_count <= retired_count + COUNT_W'(1);
            end
        end
    end

    always_comb begin
        taken = 1'b0;
        case (instr_q)
            I_BRANCH: taken = 1'b1;
            I_BZERO:  taken = zero_op;
            I_BNZERO: taken = !zero_op;
            I_BNEG:   taken = neg_op;
            I_BNNEG:  taken = !neg_op;
            I_BOV:    taken = signed_overflow | unsigned_overflow;
            I_BNOV:   taken = !(signed_overflow | unsigned_overflow);
            default:  taken = 1'b0;
        endcase
    end

    always_comb begin
        next_state       = state;
        branch           = 1'b0;
        pc_enable        = 1'b0;
        ir_enable        = 1'b0;
        addr_sel         = 1'b0;
        c_sel            = 1'b0;
        operation        = 2'b00;
        write_reg_enable = 1'b0;
        flags_reg_enable = 1'b0;
        ram_write_enable = 1'b0;
        halt             = 1'b0;

        case (state)
            ST_RESET: begin
                next_state = ST_FETCH_ADDR;
            end
            ST_FETCH_ADDR: begin
                next_state = ST_FETCH_WAIT;
            end
            ST_FETCH_WAIT: begin
                if (wait_done) begin
                    next_state = ST_FETCH_LATCH;
                end
            end
            ST_FETCH_LATCH: begin
                ir_enable  = 1'b1;
                pc_enable  = 1'b1;
                next_state = ST_DECODE;
            end
            ST_DECODE: begin
                case (decoded_instruction)
                    I_NOP:                              next_state = ST_FETCH_ADDR;
                    I_ADD, I_SUB, I_AND, I_OR, I_MOVE:  next_state = ST_EXEC_ALU;
                    I_LOAD:                             next_state = ST_LOAD_ADDR;
                    I_STORE:                            next_state = ST_STORE_ADDR;
                    I_HALT:                             next_state = ST_HALT;
                    default:                            next_state = ST_BRANCH;
                endcase
            end
            ST_EXEC_ALU: begin
                case (instr_q)
                    I_ADD:   operation = 2'b01;
                    I_SUB:   operation = 2'b10;
                    I_AND:   operation = 2'b11;
                    default: operation = 2'b00;
                endcase
                write_reg_enable = 1'b1;
                flags_reg_enable = (instr_q != I_MOVE);
                next_state       = ST_FETCH_ADDR;
            end
            ST_LOAD_ADDR: begin
                addr_sel   = 1'b1;
                next_state = ST_LOAD_WAIT;
            end
            ST_LOAD_WAIT: begin
                addr_sel = 1'b1;
                if (wait_done) begin
                    next_state = ST_LOAD_WB;
                end
            end
            ST_LOAD_WB: begin
                addr_sel         = 1'b1;
                c_sel            = 1'b1;
                write_reg_enable = 1'b1;
                next_state       = ST_FETCH_ADDR;
            end
            ST_STORE_ADDR: begin
                addr_sel   = 1'b1;
                next_state = ST_STORE_WR;
            end
            ST_STORE_WR: begin
                addr_sel         = 1'b1;
                ram_write_enable = 1'b1;
                next_state       = ST_FETCH_ADDR;
            end
            ST_BRANCH: begin
                branch     = taken;
                pc_enable  = taken;
                next_state = ST_FETCH_ADDR;
            end
            ST_HALT: begin
                halt = 1'b1;
            end
            default: begin
                next_state = ST_RESET;
            end
        endcase
    end

endmodule

// File: tb/tb_k_and_s_control_unit.sv
// tb/tb_k_and_s_control_unit.sv - self-checking bench for k_and_s_control_unit (W=1/COUNT_W=16 and W=3/COUNT_W=3 instances)
module tb_k_and_s_control_unit;
    import k_and_s_pkg::*;

    // Output vector bit positions: {branch, pc_enable, ir_enable, addr_sel, c_sel, operation[1:0], wre, fre, rwe, halt}
    localparam logic [10:0] B_BR = 11'h400, B_PC = 11'h200, B_IR = 11'h100, B_AD = 11'h080;
    localparam logic [10:0] B_CS = 11'h040, B_WR = 11'h008, B_FR = 11'h004, B_RW = 11'h002, B_HL = 11'h001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decoded_instruction_type dec [2];
    logic zero_op, neg_op, unsigned_overflow, signed_overflow;
    logic [10:0] obs [2];
    logic [15:0] cnt [2];

    int checks = 0;
    int failures = 0;
    int          wcyc  [2] = '{1, 3};
    logic [15:0] cmask [2] = '{16'hFFFF, 16'h0007};
    logic [15:0] model_cnt [2];
    logic [10:0] tl [$];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int CW = (g == 0) ? 16 : 3;
        logic br, pc, ir, ad, cs, wr, fr, rw, hl;
        logic [1:0] op;
        logic [CW-1:0] rc;
        k_and_s_control_unit #(
            .MEM_WAIT_CYCLES((g == 0) ? 1 : 3),
            .COUNT_W(CW)
        ) dut (
            .clk(clk),
            .rst_n(rst_n),
            .decoded_instruction(dec[g]),
            .zero_op(zero_op),
            .neg_op(neg_op),
            .unsigned_overflow(unsigned_overflow),
            .signed_overflow(signed_overflow),
            .branch(br),
            .pc_enable(pc),
            .ir_enable(ir),
            .addr_sel(ad),
            .c_sel(cs),
            .operation(op),
            .write_reg_enable(wr),
            .flags_reg_enable(fr),
            .ram_write_enable(rw),
            .halt(hl),
            .retired_count(rc)
        );
        assign obs[g] = {br, pc, ir, ad, cs, op, wr, fr, rw, hl};
        assign cnt[g] = 16'(rc);
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic bit cond_taken(input decoded_instruction_type ins);
        bit ov;
        ov = signed_overflow | unsigned_overflow;
        case (ins)
            I_BRANCH: return 1'b1;
            I_BZERO:  return zero_op;
            I_BNZERO: return !zero_op;
            I_BNEG:   return neg_op;
            I_BNNEG:  return !neg_op;
            I_BOV:    return ov;
            I_BNOV:   return !ov;
            default:  return 1'b0;
        endcase
    endfunction

    // Per-cycle expected outputs of one instruction, starting at its FETCH_ADDR cycle.
    task automatic build(input decoded_instruction_type ins, input int w);
        tl.delete();
        tl.push_back(11'h000);
        repeat (w) tl.push_back(11'h000);
        tl.push_back(B_IR | B_PC);
        tl.push_back(11'h000);
        case (ins)
            I_NOP, I_HALT: ;
            I_ADD:  tl.push_back(B_WR | B_FR | 11'h010);
            I_SUB:  tl.push_back(B_WR | B_FR | 11'h020);
            I_AND:  tl.push_back(B_WR | B_FR | 11'h030);
            I_OR:   tl.push_back(B_WR | B_FR);
            I_MOVE: tl.push_back(B_WR);
            I_LOAD: begin
                repeat (w + 1) tl.push_back(B_AD);
                tl.push_back(B_AD | B_CS | B_WR);
            end
            I_STORE: begin
                tl.push_back(B_AD);
                tl.push_back(B_AD | B_RW);
            end
            default: tl.push_back(cond_taken(ins) ? (B_BR | B_PC) : 11'h000);
        endcase
    endtask

    // Entered 1 ns after the edge that put DUT d in FETCH_ADDR; leaves at the same phase of the next one.
    task automatic run_instr(input int d, input decoded_instruction_type ins, input string tag);
        int dec_idx;
        dec_idx = wcyc[d] + 2;
        build(ins, wcyc[d]);
        for (int k = 0; k < tl.size(); k++) begin
            dec[d] = (k == dec_idx) ? ins : decoded_instruction_type'(4'($urandom_range(0, 15)));
            #1;
            chk($sformatf("%s_d%0d_out_c%0d", tag, d, k), 16'(obs[d]), 16'(tl[k]));
            chk($sformatf("%s_d%0d_cnt_c%0d", tag, d, k), cnt[d], model_cnt[d]);
            @(posedge clk); #1;
        end
        if (ins != I_HALT) model_cnt[d] = (model_cnt[d] + 16'd1) & cmask[d];
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_rst_out_d%0d", tag, d), 16'(obs[d]), 16'h0);
            chk($sformatf("%s_rst_cnt_d%0d", tag, d), cnt[d], 16'h0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk({tag, "_rel_out_d0"}, 16'(obs[0]), 16'h0);
        @(posedge clk); #1;
        model_cnt[0] = 16'h0;
        model_cnt[1] = 16'h0;
    endtask

    typedef struct {
        decoded_instruction_type ins;
        bit z, n, u, s;
        int cycles;
        bit taken;
    } vec_t;

    vec_t vecs [$];

    task automatic run_vec(input vec_t v, input int idx);
        int cycles;
        bit tk;
        logic [15:0] start;
        zero_op = v.z; neg_op = v.n; unsigned_overflow = v.u; signed_overflow = v.s;
        dec[0] = v.ins;
        start = cnt[0];
        cycles = 0;
        tk = 1'b0;
        while (cycles < 40) begin
            #1;
            if (obs[0][10] && obs[0][9]) tk = 1'b1;
            @(posedge clk); #1;
            cycles++;
            if (cnt[0] != start) break;
        end
        model_cnt[0] = (model_cnt[0] + 16'd1) & cmask[0];
        chk($sformatf("vec%0d_%s_cycles", idx, v.ins.name()), 16'(cycles), 16'(v.cycles));
        chk($sformatf("vec%0d_%s_taken", idx, v.ins.name()), 16'(tk), 16'(v.taken));
        chk($sformatf("vec%0d_cnt", idx), cnt[0], model_cnt[0]);
    endtask

    initial begin
        decoded_instruction_type ri;
        dec[0] = I_HALT;
        dec[1] = I_HALT;
        {zero_op, neg_op, unsigned_overflow, signed_overflow} = 4'b0;

        vecs = '{
            '{I_NOP,    0,0,0,0, 4, 0}, '{I_ADD,    0,0,0,0, 5, 0}, '{I_SUB,   0,0,0,0, 5, 0},
            '{I_AND,    0,0,0,0, 5, 0}, '{I_OR,     0,0,0,0, 5, 0}, '{I_MOVE,  0,0,0,0, 5, 0},
            '{I_LOAD,   0,0,0,0, 7, 0}, '{I_STORE,  0,0,0,0, 6, 0}, '{I_BRANCH,0,0,0,0, 5, 1},
            '{I_BZERO,  1,0,0,0, 5, 1}, '{I_BZERO,  0,0,0,0, 5, 0}, '{I_BNZERO,0,0,0,0, 5, 1},
            '{I_BNZERO, 1,0,0,0, 5, 0}, '{I_BNEG,   0,1,0,0, 5, 1}, '{I_BNEG,  0,0,0,0, 5, 0},
            '{I_BNNEG,  0,0,0,0, 5, 1}, '{I_BNNEG,  0,1,0,0, 5, 0}, '{I_BOV,   0,0,1,0, 5, 1},
            '{I_BNOV,   0,0,1,0, 5, 0}, '{I_BOV,    0,0,0,0, 5, 0}, '{I_BNOV,  0,0,0,0, 5, 1},
            '{I_BOV,    0,0,0,1, 5, 1}
        };

        #3;
        do_reset("init");
        run_instr(0, I_NOP, "first_nop");

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        for (int i = 0; i < 30; i++) begin
            ri = decoded_instruction_type'(4'($urandom_range(0, 14)));
            {zero_op, neg_op, unsigned_overflow, signed_overflow} = 4'($urandom_range(0, 15));
            run_instr(0, ri, $sformatf("rnd%0d_%s", i, ri.name()));
        end

        run_instr(0, I_HALT, "halt");
        for (int k = 0; k < 100; k++) begin
            dec[0] = decoded_instruction_type'(4'($urandom_range(0, 15)));
            #1;
            chk($sformatf("halt_hold_out_c%0d", k), 16'(obs[0]), 16'(B_HL));
            chk($sformatf("halt_hold_cnt_c%0d", k), cnt[0], model_cnt[0]);
            @(posedge clk); #1;
        end
        dec[0] = I_HALT;
        do_reset("halt_exit");
        chk("halt_exit_halt", 16'(obs[0][0]), 16'h0);

        for (int i = 0; i < 20; i++) begin
            ri = decoded_instruction_type'(4'($urandom_range(0, 14)));
            {zero_op, neg_op, unsigned_overflow, signed_overflow} = 4'($urandom_range(0, 15));
            run_instr(1, ri, $sformatf("w3_rnd%0d_%s", i, ri.name()));
        end
        run_instr(1, I_LOAD, "w3_load");
        run_instr(1, I_STORE, "w3_store");

        // Abort a W=3 LOAD in its second LOAD_WAIT cycle with an asynchronous reset.
        dec[1] = I_LOAD;
        repeat (8) begin @(posedge clk); #1; end
        chk("abort_in_load_wait", 16'(obs[1]), 16'(B_AD));
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_async", 16'(obs[1]), 16'h0);
        chk("abort_cnt_async", cnt[1], 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        model_cnt[0] = 16'h0;
        model_cnt[1] = 16'h0;
        run_instr(1, I_NOP, "restart");
        run_instr(1, I_ADD, "restart_add");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
